alu_arbiter: RTL

Shares one `alu` instance between `NREQ` requesters (e.g. execute stage and address/branch helper) with per-requester valid/ready handshakes and round-robin arbitration. Operands are registered before evaluation, and the result is held in a response register until the owning requester accepts it. Sits between issuing units and the integer datapath. Non-pipelined: at most one operation in flight.

---
 rtl/type_enums.sv | 24 ++
 rtl/alu_arbiter_alu.sv | 37 +++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/type_enums.sv
// Shared enumerations for the integer datapath: ALU opcodes and the
// state encoding of the ALU-sharing arbiter.
package type_enums;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU: wrap-around add/sub, 5-bit shift amounts,
// zero-extended set-less-than; unknown opcodes produce zero.
module alu
    import type_enums::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_t             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] out,
    output logic             out_is_zero
);

    logic [4:0] shamt;
    assign shamt = opB[4:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_ADD:  out = opA + opB;
            ALU_SUB:  out = opA - opB;
            ALU_SLL:  out = opA << shamt;
            ALU_SRL:  out = opA >> shamt;
            ALU_SRA:  out = $signed(opA) >>> shamt;
            ALU_AND:  out = opA & opB;
            ALU_OR:   out = opA | opB;
            ALU_XOR:  out = opA ^ opB;
            ALU_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU: out = {{(WIDTH-1){1'b0}}, (opA < opB)};
            default:  out = '0;
        endcase
    end

    assign out_is_zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin grant; one operation
// in flight, result held in a response register until its owner accepts it.
//
// state    | meaning
// ARB_IDLE | waiting for a request; grants one requester combinationally
// ARB_EXEC | ALU evaluates the registered operands
// ARB_RESP | result presented to its owner until that owner accepts
module alu_arbiter
    import type_enums::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  alu_t [NREQ-1:0]            req_op,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_zero,
    output logic [$clog2(NREQ)-1:0]    rsp_id
);

    localparam int IDW = $clog2(NREQ);
    typedef logic [IDW-1:0] id_t;

    arb_state_t       state_q, state_d;
    id_t              last_q, last_d;
    id_t              id_q, id_d;
    alu_t             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    id_t              pick;

    // Scan downwards so the closest valid requester after last_q wins.
    function automatic id_t rr_pick(input logic [NREQ-1:0] valid, input id_t last);
        id_t sel;
        id_t idx;
        sel = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = id_t'((int'(last) + k) % NREQ);
            if (valid[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign pick = rr_pick(req_valid, last_q);

    alu #(.WIDTH(WIDTH)) u_alu (
        .op          (op_q),
        .opA         (a_q),
        .opB         (b_q),
        .out         (alu_out),
        .out_is_zero (alu_zero)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        zero_d    = zero_q;
        req_ready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    req_ready[pick] = 1'b1;
                    op_d    = req_op[pick];
                    a_d     = req_a[pick];
                    b_d     = req_b[pick];
                    last_d  = pick;
                    id_d    = pick;
                    state_d = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                data_d  = alu_out;
                zero_d  = alu_zero;
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready[id_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= id_t'(NREQ - 1);
            id_q    <= '0;
            op_q    <= alu_t'('0);
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == ARB_RESP) rsp_valid[id_q] = 1'b1;
    end

    assign rsp_data = data_q;
    assign rsp_zero = zero_q;
    assign rsp_id   = id_q;

endmodule
